// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: FSM states and status-byte bit positions.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } mouse_state_e;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  // 9-bit signed movement; an overflowed axis contributes no motion.
  function automatic logic signed [8:0] delta9(input logic sign_bit, input logic ovf_bit,
                                               input logic [7:0] mag);
    return ovf_bit ? 9'sd0 : $signed({sign_bit, mag});
  endfunction

endpackage

// File: rtl/position_clamp.sv
// Saturates a signed coordinate into the unsigned range [0, MAX_VAL].
module position_clamp #(
  parameter int IN_W    = 12,
  parameter int OUT_W   = 10,
  parameter int MAX_VAL = 639
) (
  input  logic signed [IN_W-1:0] value_i,
  output logic [OUT_W-1:0]       value_o
);

  localparam logic signed [IN_W-1:0] MAX_S = IN_W'(MAX_VAL);

  always_comb begin
    if (value_i[IN_W-1]) begin
      value_o = '0;
    end else if (value_i > MAX_S) begin
      value_o = OUT_W'(MAX_VAL);
    end else begin
      value_o = value_i[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates them into a clamped screen cursor position.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int COLUMNS        = 640,
  parameter int ROWS           = 480,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic [$clog2(COLUMNS)-1:0] mouse_x_position_o,
  output logic [$clog2(ROWS)-1:0]    mouse_y_position_o,
  output logic                       left_button_o,
  output logic                       right_button_o,
  output logic                       packet_valid_o
);

  localparam int XW  = $clog2(COLUMNS);
  localparam int YW  = $clog2(ROWS);
  localparam int XSW = (XW + 2 > 10) ? XW + 2 : 10;
  localparam int YSW = (YW + 2 > 10) ? YW + 2 : 10;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mouse_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:4]      status_q, status_d;   // sign/overflow bits only
  logic [1:0]      btn_q, btn_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [7:0]      byte2_q, byte2_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            left_q, left_d;
  logic            right_q, right_d;
  logic            valid_q, valid_d;

  logic signed [8:0]     dx, dy;
  logic signed [XSW-1:0] sum_x;
  logic signed [YSW-1:0] sum_y;
  logic [XW-1:0]         x_clamped;
  logic [YW-1:0]         y_clamped;

  always_comb begin
    dx    = delta9(status_q[XSIGN], status_q[XOVF], byte1_q);
    dy    = delta9(status_q[YSIGN], status_q[YOVF], byte2_q);
    sum_x = $signed({{(XSW - XW){1'b0}}, x_q}) + XSW'(dx);
    // PS/2 +Y points up while screen rows grow downward.
    sum_y = $signed({{(YSW - YW){1'b0}}, y_q}) - YSW'(dy);
  end

  position_clamp #(.IN_W(XSW), .OUT_W(XW), .MAX_VAL(COLUMNS - 1)) u_clamp_x (
    .value_i (sum_x),
    .value_o (x_clamped)
  );

  position_clamp #(.IN_W(YSW), .OUT_W(YW), .MAX_VAL(ROWS - 1)) u_clamp_y (
    .value_i (sum_y),
    .value_o (y_clamped)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    btn_d    = btn_q;
    byte1_d  = byte1_q;
    byte2_d  = byte2_q;
    x_d      = x_q;
    y_d      = y_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    case (state_q)
      WAIT_B0: begin
        cnt_d = '0;
        if (rx_valid_i && rx_data_i[SYNC]) begin
          status_d = rx_data_i[7:4];
          btn_d    = rx_data_i[1:0];
          state_d  = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (rx_valid_i) begin
          byte1_d = rx_data_i;
          cnt_d   = '0;
          state_d = WAIT_B2;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_B2: begin
        if (rx_valid_i) begin
          byte2_d = rx_data_i;
          cnt_d   = '0;
          state_d = UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        x_d     = x_clamped;
        y_d     = y_clamped;
        left_d  = btn_q[LEFT];
        right_d = btn_q[RIGHT];
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_B0;
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= WAIT_B0;
      cnt_q    <= '0;
      status_q <= '0;
      btn_q    <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      x_q      <= XW'(COLUMNS / 2);
      y_q      <= YW'(ROWS / 2);
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      btn_q    <= btn_d;
      byte1_q  <= byte1_d;
      byte2_q  <= byte2_d;
      x_q      <= x_d;
      y_q      <= y_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
    end
  end

  assign mouse_x_position_o = x_q;
  assign mouse_y_position_o = y_q;
  assign left_button_o      = left_q;
  assign right_button_o     = right_q;
  assign packet_valid_o     = valid_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker with a queue of expected packet results.
module tb_mouse_position_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] mx;
  logic [8:0] my;
  logic       lb, rb, pv;

  always #5 clk = ~clk;

  mouse_position_tracker #(
    .COLUMNS(640), .ROWS(480), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .rx_data_i          (rx_data),
    .rx_valid_i         (rx_valid),
    .mouse_x_position_o (mx),
    .mouse_y_position_o (my),
    .left_button_o      (lb),
    .right_button_o     (rb),
    .packet_valid_o     (pv)
  );

  typedef struct {int x; int y; int l; int r;} exp_t;
  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Every packet_valid pulse consumes one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && pv) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("pending_expectations", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("pkt_x", mx, e.x);
        check("pkt_y", my, e.y);
        check("pkt_left", lb, e.l);
        check("pkt_right", rb, e.r);
        $display("packet: x=%0d y=%0d left=%0b right=%0b (expected %0d %0d %0d %0d)",
                 mx, my, lb, rb, e.x, e.y, e.l, e.r);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_x", mx, 320);
    check("rst_y", my, 240);
    check("rst_left", lb, 0);
    check("rst_right", rb, 0);
    check("rst_pv", pv, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] b1, input logic [7:0] b2,
                          input int gap1, input int ex, input int ey, input int el, input int er);
    exp_q.push_back('{x: ex, y: ey, l: el, r: er});
    send_byte(s);
    idle(gap1);
    send_byte(b1);
    idle(1);
    send_byte(b2);
    check("pv_early", pv, 0);
    @(negedge clk);
    check("pv_pulse", pv, 1);
    @(negedge clk);
    check("pv_single", pv, 0);
    check("x_hold", mx, ex);
    check("y_hold", my, ey);
    idle(1);
  endtask

  initial begin
    int p0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    do_reset();
    @(negedge clk);
    check("rel_x", mx, 320);
    check("rel_y", my, 240);
    check("rel_pv", pv, 0);

    // Basic packet with left button
    send_pkt(8'h09, 8'h0A, 8'h05, 1, 330, 235, 1, 0);

    // Large negative moves saturating at the edges
    do_reset();
    send_pkt(8'h38, 8'h00, 8'h10, 1, 64, 479, 0, 0);
    send_pkt(8'h38, 8'h00, 8'h10, 1, 0, 479, 0, 0);

    // Non-sync first byte dropped, then X overflow packet
    do_reset();
    send_byte(8'h00);
    idle(1);
    send_pkt(8'h48, 8'h7F, 8'h02, 1, 320, 238, 0, 0);

    // Stale status byte times out before the real packet
    do_reset();
    p0 = pulse_cnt;
    send_byte(8'h08);
    idle(150);
    check("timeout_no_pulse", pulse_cnt - p0, 0);
    send_pkt(8'h08, 8'h01, 8'h01, 1, 321, 239, 0, 0);
    check("timeout_pulses", pulse_cnt - p0, 1);

    // Byte arriving in the very cycle the timeout expires is kept
    send_pkt(8'h08, 8'h01, 8'h01, 99, 322, 238, 0, 0);

    // Reset in the middle of a packet
    send_byte(8'h09);
    idle(1);
    send_byte(8'h05);
    idle(1);
    do_reset();
    send_pkt(8'h0A, 8'h00, 8'h00, 1, 320, 240, 0, 1);

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_position_tracker.md
MOUSE_POSITION_TRACKER -- requirements
Module: mouse_position_tracker

Interface
REQ-001 SHALL have parameter COLUMNS, default 640: screen width in pixels.
REQ-002 SHALL have parameter ROWS, default 480: screen height in pixels.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000: maximum clk_i cycles between packet bytes, 25 ms at 100 MHz.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port rx_data_i, input, 8 bits: a byte received from the PS/2 receiver.
REQ-007 SHALL have port rx_valid_i, input, 1 bit: one-cycle strobe; rx_data_i is valid while it is high.
REQ-008 SHALL have port mouse_x_position_o, output, $clog2(COLUMNS) bits: cursor column.
REQ-009 SHALL have port mouse_y_position_o, output, $clog2(ROWS) bits: cursor row.
REQ-010 SHALL have port left_button_o, output, 1 bit: left button state from the last accepted packet.
REQ-011 SHALL have port right_button_o, output, 1 bit: right button state from the last accepted packet.
REQ-012 SHALL have port packet_valid_o, output, 1 bit: one-cycle pulse when the position/button outputs update.

Function
REQ-013 SHALL run an FSM with states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-014 In WAIT_B0, a byte with rx_valid_i=1 and bit3=1 SHALL be latched as the status byte and the FSM SHALL go to WAIT_B1.
REQ-015 A byte with bit3=0 received in WAIT_B0 SHALL be discarded and the FSM SHALL stay in WAIT_B0 (resynchronisation).
REQ-016 In WAIT_B1, a valid byte SHALL be latched as dx[7:0] and the FSM SHALL go to WAIT_B2.
REQ-017 In WAIT_B2, a valid byte SHALL be latched as dy[7:0] and the FSM SHALL go to UPDATE.
REQ-018 UPDATE SHALL last exactly one cycle, then the FSM SHALL return to WAIT_B0.
REQ-019 Outputs and packet_valid_o SHALL change on the clock edge leaving UPDATE, i.e. 2 cycles after the byte2 strobe.
REQ-020 rx_valid_i asserted while in UPDATE SHALL be ignored; the upstream receiver guarantees byte spacing of at least 2 cycles.
REQ-021 dx SHALL be the 9-bit two's-complement value {status[4], byte1}.
REQ-022 dy SHALL be the 9-bit two's-complement value {status[5], byte2}.
REQ-023 If status[6] (X overflow) is set, dx SHALL be treated as 0.
REQ-024 If status[7] (Y overflow) is set, dy SHALL be treated as 0.
REQ-025 new_x SHALL be x + dx.
REQ-026 new_y SHALL be y - dy, because PS/2 +Y is up and screen rows grow downward.
REQ-027 new_x and new_y SHALL be computed signed, at least 2 bits wider than the position width, without wrap.
REQ-028 new_x SHALL be clamped to [0, COLUMNS-1] and new_y to [0, ROWS-1].
REQ-029 left_button_o SHALL take status[0] and right_button_o SHALL take status[1] in UPDATE.
REQ-030 A timeout counter SHALL clear on every accepted byte and count while in WAIT_B1 or WAIT_B2.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to WAIT_B0, discard the partial packet and leave the outputs unchanged.
REQ-032 If timeout expiry and rx_valid_i occur in the same cycle, the byte SHALL win and the timeout SHALL be ignored.

Reset
REQ-033 On reset_i=1, asynchronously: FSM SHALL be WAIT_B0 and the timeout counter 0.
REQ-034 On reset_i=1, asynchronously: mouse_x_position_o SHALL be COLUMNS/2 and mouse_y_position_o ROWS/2.
REQ-035 On reset_i=1, asynchronously: left_button_o, right_button_o and packet_valid_o SHALL be 0.
REQ-036 A reset mid-packet SHALL discard the partial packet; the first byte after release SHALL be checked per REQ-014/REQ-015.

Structure
REQ-037 The FSM state enum and the PS/2 status-bit index constants (SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7) SHALL live in a shared package mouse_pkg.
REQ-038 Clamping SHALL be implemented in one parameterised sub-module, position_clamp, instantiated once per axis.
REQ-039 All other logic SHALL be contained in this module; there SHALL be no memories.

Verification (COLUMNS=640, ROWS=480, TIMEOUT_CYCLES=100)
REQ-040 Reset release -> x=320, y=240, buttons=0, packet_valid_o=0.
REQ-041 Bytes 0x09,0x0A,0x05 -> x=330, y=235, left=1, a single packet_valid_o pulse 2 cycles after byte2.
REQ-042 Bytes 0x38,0x00,0x10 (dx=-256, dy=-240) repeated twice from reset -> first x=64,y=480 clamped to 479, then x=0 (clamped), y=479.
REQ-043 Bytes 0x00 then 0x48,0x7F,0x02 -> first byte discarded; X overflow, so x=320 unchanged and y=238.
REQ-044 Byte 0x08, then 150 idle cycles, then 0x08,0x01,0x01 -> timeout resync; x=321, y=239, exactly one packet_valid_o pulse.
REQ-045 reset_i pulsed after byte1 of a packet, then 0x0A,0x00,0x00 -> x=320, y=240, right=1.
